rbe_normquant_scheduler: RTL and testbench

Sequencer for the normalization/quantization datapath. On a job start it walks output channels 0..nb_ch-1, one at a time:
- fetches the per-channel normalization parameters from a parameter stream;
- reads the matching accumulator from the accumulator bank;
- holds the operands stable on the normquant datapath for its pipeline latency;
- captures the quantized result and emits it on a valid/ready output stream.

It sits between the accumulator bank / parameter streamer and the output streamer.

---
 rtl/rbe_normquant_scheduler.sv | 147 ++++++++++++++
 tb/tb_rbe_normquant_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rbe_normquant_scheduler.sv
// Channel sequencer for the norm/quant datapath: per channel it fetches parameters,
// reads the accumulator, waits out the datapath pipeline and streams the result.
module rbe_normquant_scheduler #(
  parameter int NR_CH = 32,
  parameter int PIPE  = 1,
  parameter int NMS   = 8,
  parameter int NAS   = 32,
  parameter int ACC   = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       start_i,
  input  logic [$clog2(NR_CH+1)-1:0] nb_ch_i,
  input  logic [4:0]                 right_shift_i,
  input  logic [3:0]                 qa_out_i,
  input  logic                       relu_i,
  output logic                       busy_o,
  output logic                       done_o,
  input  logic                       param_valid_i,
  output logic                       param_ready_o,
  input  logic [NMS-1:0]             param_mult_i,
  input  logic [NAS-1:0]             param_add_i,
  output logic                       acc_rd_o,
  output logic [$clog2(NR_CH)-1:0]   acc_addr_o,
  input  logic [ACC-1:0]             acc_rdata_i,
  output logic                       nq_clear_o,
  output logic [NMS-1:0]             nq_norm_mult_o,
  output logic [NAS-1:0]             nq_norm_add_o,
  output logic [ACC-1:0]             nq_acc_o,
  output logic [4:0]                 nq_right_shift_o,
  output logic [3:0]                 nq_qa_out_o,
  output logic                       nq_relu_o,
  input  logic [ACC-1:0]             nq_result_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [ACC-1:0]             out_data_o,
  output logic [$clog2(NR_CH)-1:0]   out_ch_o
);
  localparam int NW = $clog2(NR_CH+1);
  localparam int CW = $clog2(NR_CH);
  localparam int WW = $clog2(PIPE+2);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, OUT, DONE} state_e;

  state_e          state_q, state_d;
  logic [NW-1:0]   nb_ch_q;
  logic [CW-1:0]   k_q;
  logic [4:0]      shift_q;
  logic [3:0]      qa_q;
  logic            relu_q;
  logic [NMS-1:0]  mult_q;
  logic [NAS-1:0]  add_q;
  logic [ACC-1:0]  acc_q, res_q;
  logic [WW-1:0]   wcnt_q;
  logic            last_ch, wait_end;

  assign last_ch  = (NW'(k_q) + NW'(1)) == nb_ch_q;
  assign wait_end = wcnt_q == WW'(PIPE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Handshake outputs are masked by clear so nothing is consumed from a stream
  // in the cycle the job is being torn down.
  always_comb begin
    state_d       = state_q;
    busy_o        = state_q != IDLE;
    done_o        = 1'b0;
    param_ready_o = 1'b0;
    acc_rd_o      = 1'b0;
    out_valid_o   = 1'b0;
    case (state_q)
      IDLE:  if (start_i) state_d = (nb_ch_i == '0) ? DONE : FETCH;
      FETCH: begin
        param_ready_o = !clear_i;
        acc_rd_o      = param_valid_i && !clear_i;
        if (param_valid_i) state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT:  if (wait_end) state_d = OUT;
      OUT: begin
        out_valid_o = !clear_i;
        if (out_ready_i) state_d = last_ch ? DONE : FETCH;
      end
      DONE: begin
        done_o  = !clear_i;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || clear_i) begin
      nb_ch_q <= '0;
      k_q     <= '0;
      shift_q <= '0;
      qa_q    <= '0;
      relu_q  <= 1'b0;
      mult_q  <= '0;
      add_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          nb_ch_q <= nb_ch_i;
          shift_q <= right_shift_i;
          qa_q    <= qa_out_i;
          relu_q  <= relu_i;
          k_q     <= '0;
        end
        FETCH: if (param_valid_i) begin
          mult_q <= param_mult_i;
          add_q  <= param_add_i;
        end
        ISSUE: begin
          acc_q  <= acc_rdata_i;
          wcnt_q <= '0;
        end
        WAIT: begin
          if (wait_end) res_q <= nq_result_i;
          else          wcnt_q <= wcnt_q + WW'(1);
        end
        OUT: if (out_ready_i && !last_ch) k_q <= k_q + CW'(1);
        default: ;
      endcase
    end
  end

  assign acc_addr_o       = k_q;
  assign out_ch_o         = k_q;
  assign out_data_o       = res_q;
  assign nq_clear_o       = clear_i;
  assign nq_norm_mult_o   = mult_q;
  assign nq_norm_add_o    = add_q;
  assign nq_acc_o         = acc_q;
  assign nq_right_shift_o = shift_q;
  assign nq_qa_out_o      = qa_q;
  assign nq_relu_o        = relu_q;

endmodule

// File: tb/tb_rbe_normquant_scheduler.sv
// Bench for rbe_normquant_scheduler: behavioural accumulator bank and norm/quant
// datapath around the DUT, per-scenario tasks compare against a channel-list model.
module tb_rbe_normquant_scheduler;
  localparam int NR_CH = 32, PIPE = 1, NMS = 8, NAS = 32, ACC = 32;
  localparam int NW = $clog2(NR_CH+1), CW = $clog2(NR_CH);

  logic clk_i = 0, rst_i = 1, clear_i = 0, start_i = 0;
  logic [NW-1:0] nb_ch_i = '0;
  logic [4:0] right_shift_i = '0;
  logic [3:0] qa_out_i = '0;
  logic relu_i = 0, busy_o, done_o, param_valid_i = 0, param_ready_o;
  logic [NMS-1:0] param_mult_i = '0;
  logic [NAS-1:0] param_add_i = '0;
  logic acc_rd_o, nq_clear_o, nq_relu_o, out_valid_o, out_ready_i = 0;
  logic [CW-1:0] acc_addr_o, out_ch_o;
  logic [ACC-1:0] acc_rdata_i, nq_acc_o, nq_result_i, out_data_o;
  logic [NMS-1:0] nq_norm_mult_o;
  logic [NAS-1:0] nq_norm_add_o;
  logic [4:0] nq_right_shift_o;
  logic [3:0] nq_qa_out_o;

  rbe_normquant_scheduler #(.NR_CH(NR_CH), .PIPE(PIPE), .NMS(NMS), .NAS(NAS), .ACC(ACC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i), .nb_ch_i(nb_ch_i),
    .right_shift_i(right_shift_i), .qa_out_i(qa_out_i), .relu_i(relu_i), .busy_o(busy_o),
    .done_o(done_o), .param_valid_i(param_valid_i), .param_ready_o(param_ready_o),
    .param_mult_i(param_mult_i), .param_add_i(param_add_i), .acc_rd_o(acc_rd_o),
    .acc_addr_o(acc_addr_o), .acc_rdata_i(acc_rdata_i), .nq_clear_o(nq_clear_o),
    .nq_norm_mult_o(nq_norm_mult_o), .nq_norm_add_o(nq_norm_add_o), .nq_acc_o(nq_acc_o),
    .nq_right_shift_o(nq_right_shift_o), .nq_qa_out_o(nq_qa_out_o), .nq_relu_o(nq_relu_o),
    .nq_result_i(nq_result_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_ch_o(out_ch_o));

  always #5 clk_i = ~clk_i;

  int n_cmp = 0, n_err = 0;

  // Norm/quant reference: (acc*mult + add) >>> shift, clamped to [0, 2^qa-1].
  function automatic logic [ACC-1:0] nq_ref(input logic [ACC-1:0] a, input logic [NMS-1:0] m,
                                            input logic [NAS-1:0] d, input logic [4:0] sh,
                                            input logic [3:0] qa);
    longint v, hi;
    v  = longint'($signed(a)) * longint'({1'b0, m}) + longint'($signed(d));
    v  = v >>> sh;
    hi = (longint'(1) << qa) - 1;
    if (v < 0) v = 0;
    else if (v > hi) v = hi;
    return ACC'(v);
  endfunction

  logic [ACC-1:0] acc_mem [NR_CH];
  logic [NMS-1:0] mult_arr [NR_CH];
  logic [NAS-1:0] add_arr [NR_CH];

  // Accumulator bank (garbage when not read) and a PIPE=1 datapath with no output register.
  always @(posedge clk_i) acc_rdata_i <= acc_rd_o ? acc_mem[acc_addr_o] : ACC'($urandom);
  always @(posedge clk_i)
    nq_result_i <= nq_ref(nq_acc_o, nq_norm_mult_o, nq_norm_add_o, nq_right_shift_o, nq_qa_out_o);

  logic [ACC-1:0] obs_data[$];
  int obs_ch[$], obs_t[$];
  int done_cnt, done_t, busy_low_t, rd_cnt, rd_bad, addr_bad, stall_bad, jobreg_bad;
  int pr_cnt, ov_cnt, post_clear_bad, clr_t;
  bit timed_out;

  task automatic fill_random(input int nb);
    for (int i = 0; i < NR_CH; i++) begin
      acc_mem[i]  = ACC'($urandom_range(0, 4000)) - ACC'(2000);
      mult_arr[i] = NMS'($urandom);
      add_arr[i]  = NAS'($urandom_range(0, 600)) - NAS'(300);
    end
  endtask

  // Drives one job cycle by cycle and records what the DUT did; scenarios judge the record.
  task automatic run_job(input int nb, input logic [4:0] sh, input logic [3:0] qa, input logic rl,
                         input int pv_pct, input int rdy_pct, input int oc_ch, input int oc_len,
                         input int pc_ch, input int pc_len, input int clr_ch, input int restart_t);
    int t = 0, pidx = 0, ostall = 0, pstall = 0;
    bit prev_stall = 0;
    logic [ACC-1:0] prev_d = '0;
    logic [CW-1:0] prev_ch = '0;
    obs_data.delete(); obs_ch.delete(); obs_t.delete();
    done_cnt = 0; done_t = -1; busy_low_t = -1; rd_cnt = 0; rd_bad = 0; addr_bad = 0;
    stall_bad = 0; jobreg_bad = 0; pr_cnt = 0; ov_cnt = 0; post_clear_bad = 0; clr_t = -1;
    timed_out = 1;
    @(negedge clk_i);
    start_i = 1; nb_ch_i = NW'(nb); right_shift_i = sh; qa_out_i = qa; relu_i = rl;
    param_valid_i = 0; out_ready_i = 0; clear_i = 0;
    while (t < 3000) begin
      @(negedge clk_i); t++;
      start_i = (t == restart_t);
      nb_ch_i = NW'(NR_CH); right_shift_i = ~sh; qa_out_i = ~qa; relu_i = ~rl;
      clear_i = (t == clr_t);
      param_mult_i = mult_arr[pidx % NR_CH];
      param_add_i  = add_arr[pidx % NR_CH];
      if (pidx == pc_ch && pstall < pc_len && param_ready_o) begin
        param_valid_i = 0; pstall++;
      end else param_valid_i = (pidx < nb) && ($urandom_range(99) < pv_pct);
      if (out_valid_o && int'(out_ch_o) == oc_ch && ostall < oc_len) begin
        out_ready_i = 0; ostall++;
      end else out_ready_i = ($urandom_range(99) < rdy_pct);
      #1;
      if (param_ready_o) pr_cnt++;
      if (busy_o && (clr_t < 0 || t <= clr_t) &&
          (nq_right_shift_o !== sh || nq_qa_out_o !== qa || nq_relu_o !== rl)) jobreg_bad++;
      if (acc_rd_o) begin
        rd_cnt++;
        if (!param_valid_i) rd_bad++;
        if (acc_addr_o !== CW'(pidx)) addr_bad++;
        if (pidx == clr_ch) clr_t = t + 2;
      end
      if (param_valid_i && param_ready_o) pidx++;
      if (out_valid_o) ov_cnt++;
      if (out_valid_o && prev_stall && (out_data_o !== prev_d || out_ch_o !== prev_ch)) stall_bad++;
      prev_stall = out_valid_o && !out_ready_i; prev_d = out_data_o; prev_ch = out_ch_o;
      if (out_valid_o && out_ready_i) begin
        obs_data.push_back(out_data_o); obs_ch.push_back(int'(out_ch_o)); obs_t.push_back(t);
      end
      if (done_o) begin done_cnt++; done_t = t; end
      if (t == clr_t && nq_clear_o !== 1'b1) post_clear_bad++;
      if (clr_t >= 0 && t == clr_t + 1 &&
          (busy_o || done_o || param_ready_o || acc_rd_o || out_valid_o || out_data_o != 0 ||
           out_ch_o != 0 || acc_addr_o != 0 || nq_acc_o != 0 || nq_norm_mult_o != 0 ||
           nq_norm_add_o != 0 || nq_right_shift_o != 0 || nq_qa_out_o != 0 || nq_relu_o)) post_clear_bad++;
      if (done_t >= 0 && busy_low_t < 0 && !busy_o) busy_low_t = t;
      if (busy_low_t >= 0 || (clr_t >= 0 && t > clr_t + 3)) begin timed_out = 0; break; end
    end
    start_i = 0; clear_i = 0; param_valid_i = 0; out_ready_i = 0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({busy_o, done_o, param_ready_o, acc_rd_o, out_valid_o} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 00000", {busy_o, done_o, param_ready_o, acc_rd_o, out_valid_o});
    end
    n_cmp++;
    if (out_data_o !== '0 || out_ch_o !== '0 || acc_addr_o !== '0 || nq_acc_o !== '0 ||
        nq_norm_mult_o !== '0 || nq_norm_add_o !== '0) begin
      n_err++; $display("FAIL reset_data: got data=%0h ch=%0d addr=%0d nq_acc=%0h want all 0",
                        out_data_o, out_ch_o, acc_addr_o, nq_acc_o);
    end
    @(negedge clk_i); rst_i = 0; #1;
    n_cmp++;
    if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_release_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_single();
    fill_random(1);
    acc_mem[0] = 300; mult_arr[0] = 1; add_arr[0] = 0;
    run_job(1, 0, 8, 0, 100, 100, -1, 0, -1, 0, -1, -1);
    n_cmp++;
    if (obs_data.size() != 1 || obs_data[0] !== 255 || obs_ch[0] != 0) begin
      n_err++; $display("FAIL single_result: got n=%0d data=%0d want n=1 data=255 ch=0",
                        obs_data.size(), obs_data.size() ? obs_data[0] : 0);
    end
    n_cmp++;
    if (obs_t.size() != 1 || obs_t[0] != 5) begin
      n_err++; $display("FAIL single_valid_cycle: got %0d want 5", obs_t.size() ? obs_t[0] : -1);
    end
    n_cmp++;
    if (done_t != 6 || done_cnt != 1) begin
      n_err++; $display("FAIL single_done: got cycle=%0d count=%0d want cycle=6 count=1", done_t, done_cnt);
    end
    n_cmp++;
    if (busy_low_t != 7 || timed_out) begin
      n_err++; $display("FAIL single_busy_low: got %0d timeout=%0d want 7", busy_low_t, timed_out);
    end
  endtask

  task automatic test_four();
    fill_random(4);
    for (int i = 0; i < 4; i++) begin acc_mem[i] = ACC'(10 * (i + 1)); mult_arr[i] = 2; add_arr[i] = 0; end
    run_job(4, 0, 8, 0, 100, 100, -1, 0, -1, 0, -1, -1);
    n_cmp++;
    if (obs_data.size() != 4 || timed_out) begin
      n_err++; $display("FAIL four_count: got %0d timeout=%0d want 4", obs_data.size(), timed_out);
    end
    for (int i = 0; i < obs_data.size() && i < 4; i++) begin
      n_cmp++;
      if (obs_data[i] !== ACC'(20 * (i + 1)) || obs_ch[i] != i || obs_t[i] != 5 + 5 * i) begin
        n_err++; $display("FAIL four_res[%0d]: got data=%0d ch=%0d t=%0d want data=%0d ch=%0d t=%0d",
                          i, obs_data[i], obs_ch[i], obs_t[i], 20 * (i + 1), i, 5 + 5 * i);
      end
    end
    n_cmp++;
    if (done_cnt != 1 || done_t != 21) begin
      n_err++; $display("FAIL four_done: got count=%0d cycle=%0d want 1 at 21", done_cnt, done_t);
    end
  endtask

  task automatic test_backpressure();
    fill_random(4);
    run_job(4, 3, 10, 1, 100, 100, 1, 7, 2, 3, -1, -1);
    n_cmp++;
    if (obs_data.size() != 4 || timed_out) begin
      n_err++; $display("FAIL bp_count: got %0d timeout=%0d want 4", obs_data.size(), timed_out);
    end
    for (int i = 0; i < obs_data.size() && i < 4; i++) begin
      n_cmp++;
      if (obs_data[i] !== nq_ref(acc_mem[i], mult_arr[i], add_arr[i], 3, 10) || obs_ch[i] != i) begin
        n_err++; $display("FAIL bp_res[%0d]: got data=%0d ch=%0d want data=%0d ch=%0d", i, obs_data[i],
                          obs_ch[i], nq_ref(acc_mem[i], mult_arr[i], add_arr[i], 3, 10), i);
      end
    end
    n_cmp++;
    if (obs_t.size() == 4 && (obs_t[1] != 17 || obs_t[2] != 25)) begin
      n_err++; $display("FAIL bp_timing: got ch1=%0d ch2=%0d want 17 25", obs_t[1], obs_t[2]);
    end
    n_cmp++;
    if (stall_bad != 0 || rd_bad != 0 || addr_bad != 0 || rd_cnt != 4) begin
      n_err++; $display("FAIL bp_hold: got stall=%0d rd_bad=%0d addr_bad=%0d rd=%0d want 0 0 0 4",
                        stall_bad, rd_bad, addr_bad, rd_cnt);
    end
  endtask

  task automatic test_zero();
    run_job(0, 0, 8, 0, 100, 100, -1, 0, -1, 0, -1, -1);
    n_cmp++;
    if (pr_cnt != 0 || rd_cnt != 0 || ov_cnt != 0) begin
      n_err++; $display("FAIL zero_quiet: got ready=%0d rd=%0d valid=%0d want 0 0 0", pr_cnt, rd_cnt, ov_cnt);
    end
    n_cmp++;
    if (done_cnt != 1 || done_t != 1 || timed_out) begin
      n_err++; $display("FAIL zero_done: got count=%0d cycle=%0d want 1 at 1", done_cnt, done_t);
    end
  endtask

  task automatic test_clear();
    fill_random(4);
    run_job(4, 1, 12, 0, 100, 100, -1, 0, -1, 0, 2, -1);
    n_cmp++;
    if (clr_t < 0 || post_clear_bad != 0 || done_cnt != 0 || obs_data.size() != 2) begin
      n_err++; $display("FAIL clear_abort: got clr=%0d bad=%0d done=%0d n=%0d want bad=0 done=0 n=2",
                        clr_t, post_clear_bad, done_cnt, obs_data.size());
    end
    fill_random(3);
    run_job(3, 2, 9, 0, 80, 80, -1, 0, -1, 0, -1, -1);
    n_cmp++;
    if (obs_data.size() != 3 || done_cnt != 1 || timed_out) begin
      n_err++; $display("FAIL clear_restart: got n=%0d done=%0d want 3 1", obs_data.size(), done_cnt);
    end
    for (int i = 0; i < obs_data.size() && i < 3; i++) begin
      n_cmp++;
      if (obs_data[i] !== nq_ref(acc_mem[i], mult_arr[i], add_arr[i], 2, 9) || obs_ch[i] != i) begin
        n_err++; $display("FAIL clear_res[%0d]: got %0d want %0d", i, obs_data[i],
                          nq_ref(acc_mem[i], mult_arr[i], add_arr[i], 2, 9));
      end
    end
  endtask

  task automatic test_start_busy();
    fill_random(3);
    run_job(3, 4, 7, 1, 100, 100, -1, 0, -1, 0, -1, 3);
    n_cmp++;
    if (obs_data.size() != 3 || done_cnt != 1 || jobreg_bad != 0 || timed_out) begin
      n_err++; $display("FAIL start_busy: got n=%0d done=%0d jobreg_bad=%0d want 3 1 0",
                        obs_data.size(), done_cnt, jobreg_bad);
    end
  endtask

  task automatic test_reset_out();
    bit seen = 0;
    fill_random(2);
    @(negedge clk_i);
    start_i = 1; nb_ch_i = 2; right_shift_i = 1; qa_out_i = 6; relu_i = 1;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk_i);
      start_i = 0; param_valid_i = 1; param_mult_i = mult_arr[0]; param_add_i = add_arr[0];
      out_ready_i = 0; #1;
      seen = out_valid_o;
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL rst_out_reach: got no out_valid want OUT within 20 cycles"); end
    #2 rst_i = 1; #1;
    n_cmp++;
    if ({busy_o, done_o, param_ready_o, acc_rd_o, out_valid_o} !== 5'b0 || out_data_o !== '0 ||
        out_ch_o !== '0 || nq_acc_o !== '0 || nq_right_shift_o !== '0 || nq_relu_o !== 1'b0) begin
      n_err++; $display("FAIL rst_out_zero: got ctrl=%b data=%0h want all 0",
                        {busy_o, done_o, param_ready_o, acc_rd_o, out_valid_o}, out_data_o);
    end
    @(negedge clk_i); rst_i = 0; param_valid_i = 0; #1;
    n_cmp++;
    if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_out_idle: got busy=%b want 0", busy_o); end
  endtask

  task automatic test_random();
    for (int j = 0; j < 4; j++) begin
      int nb = $urandom_range(1, NR_CH);
      logic [4:0] sh = 5'($urandom_range(0, 6));
      logic [3:0] qa = 4'($urandom_range(2, 12));
      fill_random(nb);
      run_job(nb, sh, qa, 1'($urandom), 70, 70, -1, 0, -1, 0, -1, -1);
      n_cmp++;
      if (obs_data.size() != nb || done_cnt != 1 || timed_out || stall_bad != 0 || rd_bad != 0 ||
          addr_bad != 0 || jobreg_bad != 0) begin
        n_err++; $display("FAIL rand_job%0d: got n=%0d done=%0d stall=%0d rd=%0d addr=%0d jr=%0d want n=%0d",
                          j, obs_data.size(), done_cnt, stall_bad, rd_bad, addr_bad, jobreg_bad, nb);
      end
      for (int i = 0; i < obs_data.size() && i < nb; i++) begin
        n_cmp++;
        if (obs_data[i] !== nq_ref(acc_mem[i], mult_arr[i], add_arr[i], sh, qa) || obs_ch[i] != i) begin
          n_err++; $display("FAIL rand_res[%0d][%0d]: got data=%0d ch=%0d want data=%0d ch=%0d", j, i,
                            obs_data[i], obs_ch[i], nq_ref(acc_mem[i], mult_arr[i], add_arr[i], sh, qa), i);
        end
      end
    end
  endtask

  initial begin
    fill_random(NR_CH);
    test_reset();
    test_single();
    test_four();
    test_backpressure();
    test_zero();
    test_clear();
    test_start_busy();
    test_reset_out();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
